// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// forwarding-mux selects and the register-match helper.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } ctrl_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // x0 is hard-wired zero, so a write to it never produces a dependency
   function automatic logic reg_hit(input logic [4:0] rs, input logic [4:0] rd, input logic wr);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the 5-stage datapath (master) and the stall/flush
// sequencer (slave): stage register addresses/controls in, enables/flushes out.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       rs1Addr_id;
   logic             rs1Used_id;
   logic [4:0]       rs2Addr_id;
   logic             rs2Used_id;
   logic [4:0]       rdAddr_ex;
   logic             RegWrite_ex;
   logic             MemRead_ex;
   logic [4:0]       rdAddr_mem;
   logic             RegWrite_mem;
   logic             MemRead_mem;
   logic             MemWrite_mem;
   logic [4:0]       rdAddr_wb;
   logic             RegWrite_wb;
   logic             BranchTaken_ex;
   logic             MemReady_mem;
   logic             PCWrite;
   logic             IF_ID_en;
   logic             IF_ID_flush;
   logic             ID_EX_en;
   logic             ID_EX_flush;
   logic             EX_MEM_en;
   logic             EX_MEM_flush;
   logic             MEM_WB_en;
   logic             MEM_WB_flush;
   logic [1:0]       ForwardA;
   logic [1:0]       ForwardB;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output rs1Addr_id, rs1Used_id, rs2Addr_id, rs2Used_id,
      output rdAddr_ex, RegWrite_ex, MemRead_ex,
      output rdAddr_mem, RegWrite_mem, MemRead_mem, MemWrite_mem,
      output rdAddr_wb, RegWrite_wb, BranchTaken_ex, MemReady_mem,
      input  PCWrite, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
      input  EX_MEM_en, EX_MEM_flush, MEM_WB_en, MEM_WB_flush,
      input  ForwardA, ForwardB, mem_err, stall_cnt
   );

   modport slave (
      input  rs1Addr_id, rs1Used_id, rs2Addr_id, rs2Used_id,
      input  rdAddr_ex, RegWrite_ex, MemRead_ex,
      input  rdAddr_mem, RegWrite_mem, MemRead_mem, MemWrite_mem,
      input  rdAddr_wb, RegWrite_wb, BranchTaken_ex, MemReady_mem,
      output PCWrite, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
      output EX_MEM_en, EX_MEM_flush, MEM_WB_en, MEM_WB_flush,
      output ForwardA, ForwardB, mem_err, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard detection and forwarding select for the ID stage.
// PIPE_FORWARD_EN selects load-use-only stalls with EX operand forwarding.
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_addr,
   input  logic       rs1_used,
   input  logic [4:0] rs2_addr,
   input  logic       rs2_used,
   input  logic [4:0] rd_ex,
   input  logic       reg_write_ex,
   input  logic [4:0] rd_mem,
   input  logic       reg_write_mem,
   input  logic [4:0] rd_wb,
   input  logic       reg_write_wb,
`ifdef PIPE_FORWARD_EN
   input  logic       mem_read_ex,
   input  logic       mem_read_mem,
`endif
   output logic       data_stall,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

`ifdef PIPE_FORWARD_EN
   // Only a load still in EX cannot be forwarded in time; MEM wins over WB as the newer value
   always_comb begin
      data_stall = mem_read_ex &&
                   ((rs1_used && reg_hit(rs1_addr, rd_ex, reg_write_ex)) ||
                    (rs2_used && reg_hit(rs2_addr, rd_ex, reg_write_ex)));
      fwd_a = FWD_RF;
      if (reg_hit(rs1_addr, rd_mem, reg_write_mem && !mem_read_mem)) fwd_a = FWD_MEM;
      else if (reg_hit(rs1_addr, rd_wb, reg_write_wb))              fwd_a = FWD_WB;
      fwd_b = FWD_RF;
      if (reg_hit(rs2_addr, rd_mem, reg_write_mem && !mem_read_mem)) fwd_b = FWD_MEM;
      else if (reg_hit(rs2_addr, rd_wb, reg_write_wb))              fwd_b = FWD_WB;
   end
`else
   // Without a bypass network any pending writer of a used source must drain first
   always_comb begin
      data_stall = (rs1_used && (reg_hit(rs1_addr, rd_ex,  reg_write_ex)  ||
                                 reg_hit(rs1_addr, rd_mem, reg_write_mem) ||
                                 reg_hit(rs1_addr, rd_wb,  reg_write_wb))) ||
                   (rs2_used && (reg_hit(rs2_addr, rd_ex,  reg_write_ex)  ||
                                 reg_hit(rs2_addr, rd_mem, reg_write_mem) ||
                                 reg_hit(rs2_addr, rd_wb,  reg_write_wb)));
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
   end
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-wait timeout FSM
// and saturating stall counter. Optional forwarding via `define PIPE_FORWARD_EN.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input logic             clk,
   input logic             rst,
   pipeline_ctrl_if.slave  bus
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   ctrl_state_e      state_q, state_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_stall, data_stall, pc_write;
   logic [1:0]       fwd_a, fwd_b;

   pipe_hazard_detect u_hazard (
      .rs1_addr      (bus.rs1Addr_id),
      .rs1_used      (bus.rs1Used_id),
      .rs2_addr      (bus.rs2Addr_id),
      .rs2_used      (bus.rs2Used_id),
      .rd_ex         (bus.rdAddr_ex),
      .reg_write_ex  (bus.RegWrite_ex),
      .rd_mem        (bus.rdAddr_mem),
      .reg_write_mem (bus.RegWrite_mem),
      .rd_wb         (bus.rdAddr_wb),
      .reg_write_wb  (bus.RegWrite_wb),
`ifdef PIPE_FORWARD_EN
      .mem_read_ex   (bus.MemRead_ex),
      .mem_read_mem  (bus.MemRead_mem),
`endif
      .data_stall    (data_stall),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   assign mem_stall = (bus.MemRead_mem || bus.MemWrite_mem) && !bus.MemReady_mem;

   // Priority: reset, error lock-up, memory freeze, redirect, data stall, run
   always_comb begin
      pc_write          = 1'b1;
      bus.IF_ID_en      = 1'b1;
      bus.IF_ID_flush   = 1'b0;
      bus.ID_EX_en      = 1'b1;
      bus.ID_EX_flush   = 1'b0;
      bus.EX_MEM_en     = 1'b1;
      bus.EX_MEM_flush  = 1'b0;
      bus.MEM_WB_en     = 1'b1;
      bus.MEM_WB_flush  = 1'b0;
      if (rst) begin
         pc_write = 1'b0;
         {bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en} = 4'b0000;
         {bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush, bus.MEM_WB_flush} = 4'b1111;
      end else if (state_q == ST_ERR) begin
         pc_write = 1'b0;
         {bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en} = 4'b0000;
      end else if (mem_stall) begin
         pc_write         = 1'b0;
         bus.IF_ID_en     = 1'b0;
         bus.ID_EX_en     = 1'b0;
         bus.EX_MEM_en    = 1'b0;
         bus.MEM_WB_flush = 1'b1;
      end else if (bus.BranchTaken_ex) begin
         bus.IF_ID_flush  = 1'b1;
         bus.ID_EX_flush  = 1'b1;
      end else if (data_stall) begin
         pc_write         = 1'b0;
         bus.IF_ID_en     = 1'b0;
         bus.ID_EX_flush  = 1'b1;
      end
   end

   // Memory-wait FSM: tmo counts MEM_WAIT cycles spent without the memory answering
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            tmo_d = 8'd0;
            if (mem_stall) state_d = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (!mem_stall) begin
               state_d = ST_RUN;
               tmo_d   = 8'd0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_ERR;
            err_d   = 1'b1;
         end
      endcase
      if (state_q != ST_ERR && !pc_write && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         tmo_q   <= 8'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.PCWrite   = pc_write;
   assign bus.ForwardA  = fwd_a;
   assign bus.ForwardB  = fwd_b;
   assign bus.mem_err   = err_q;
   assign bus.stall_cnt = cnt_q;

endmodule
